// File: rtl/colisor_pkg.sv
// colisor_pkg: shared defaults, FSM states and grid helpers
// for the shot-resolution stage.
package colisor_pkg;

    localparam int GRID_DEF      = 9;
    localparam int MAX_SHIPS_DEF = 9;
    localparam int CW_DEF        = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE,
        DONE
    } state_t;

    // Linear cell index of 1-based (x,y); only meaningful in range.
    function automatic int cell_idx(input int x, input int y,
                                    input int g);
        return (y - 1) * g + (x - 1);
    endfunction

    // 1 <= x,y <= g; coordinate 0 is the out-of-range sentinel.
    function automatic logic in_range(input int x, input int y,
                                      input int g);
        return (x >= 1) && (x <= g) && (y >= 1) && (y <= g);
    endfunction

endpackage

// File: rtl/board_bitmap.sv
// board_bitmap: one player's ship/hit cell vectors.
// COLISOR_MISS_MAP_EN adds a miss vector.
module board_bitmap #(
    parameter int CELLS = 81,
    parameter int IW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_ship,
    output logic          rd_hit,
    input  logic [IW-1:0] set_idx,
    input  logic          set_ship,
    input  logic          set_hit
`ifdef COLISOR_MISS_MAP_EN
    ,
    output logic          rd_miss,
    input  logic          set_miss
`endif
);

    logic [CELLS-1:0] ship;
    logic [CELLS-1:0] hit;
    logic             rd_ok;

    assign rd_ok = int'(rd_idx) < CELLS;

    // Combinational read port, guarded against unused indices.
    assign rd_ship = rd_ok ? ship[rd_idx] : 1'b0;
    assign rd_hit  = rd_ok ? hit[rd_idx]  : 1'b0;

    // Ship and hit bits: async reset, sync clear, bit-set port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ship <= '0;
            hit  <= '0;
        end else if (clear) begin
            ship <= '0;
            hit  <= '0;
        end else begin
            if (set_ship)
                ship[set_idx] <= 1'b1;
            if (set_hit)
                hit[set_idx] <= 1'b1;
        end
    end

`ifdef COLISOR_MISS_MAP_EN
    logic [CELLS-1:0] miss;

    assign rd_miss = rd_ok ? miss[rd_idx] : 1'b0;

    // Miss bits share the clear/reset behaviour of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            miss <= '0;
        else if (clear)
            miss <= '0;
        else if (set_miss)
            miss[set_idx] <= 1'b1;
    end
`endif

endmodule

// File: rtl/colisor_tiro.sv
// colisor_tiro: resolves shots against two 9x9 ship maps.
// Optional COLISOR_MISS_MAP_EN keeps a miss map per player.
module colisor_tiro
    import colisor_pkg::*;
#(
    parameter int GRID      = GRID_DEF,
    parameter int MAX_SHIPS = MAX_SHIPS_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          place_we,
    input  logic          place_player,
    input  logic [CW-1:0] place_x,
    input  logic [CW-1:0] place_y,
    output logic          place_err,
    input  logic          shot_req,
    input  logic          shot_target,
    input  logic [CW-1:0] shot_x,
    input  logic [CW-1:0] shot_y,
    output logic          acertou_tiro,
    output logic          shot_repeat,
    output logic          shot_done,
    output logic [CW-1:0] qtd_P1,
    output logic [CW-1:0] qtd_P2
);

    localparam int CELLS = GRID * GRID;
    localparam int IW    = $clog2(CELLS);

    state_t        state, state_n;
    logic          req_prev, req_edge;
    logic          tgt;
    logic [CW-1:0] sx, sy;
    logic          l_rng, l_ship, l_hit;

    logic          capture, lookup, res_load, out_clr;
    logic          hit_now, rep_now;
    logic          place_do, place_rej, clear_do;

    logic          place_rng, shot_rng;
    logic [IW-1:0] place_idx, shot_idx;
    logic [IW-1:0] rd_idx, set_idx;
    logic          rd_p;
    logic          p1_ship, p1_hit, p2_ship, p2_hit;
    logic          sel_ship, sel_hit;
    logic          full;

`ifdef COLISOR_MISS_MAP_EN
    logic          l_miss, miss_now;
    logic          p1_miss, p2_miss, sel_miss;
`endif

    assign req_edge  = shot_req & ~req_prev;

    assign place_rng = in_range(int'(place_x), int'(place_y), GRID);
    assign shot_rng  = in_range(int'(sx), int'(sy), GRID);
    assign place_idx = IW'(cell_idx(int'(place_x),
                                    int'(place_y), GRID));
    assign shot_idx  = IW'(cell_idx(int'(sx), int'(sy), GRID));

    // Placement owns the board ports only while idle.
    assign rd_idx  = (state == IDLE) ? place_idx : shot_idx;
    assign set_idx = rd_idx;
    assign rd_p    = (state == IDLE) ? place_player : tgt;

    assign sel_ship = rd_p ? p2_ship : p1_ship;
    assign sel_hit  = rd_p ? p2_hit  : p1_hit;
`ifdef COLISOR_MISS_MAP_EN
    assign sel_miss = rd_p ? p2_miss : p1_miss;
`endif

    assign full = place_player ? (qtd_P2 == CW'(MAX_SHIPS))
                               : (qtd_P1 == CW'(MAX_SHIPS));

    board_bitmap #(.CELLS(CELLS), .IW(IW)) u_board_p1 (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_do),
        .rd_idx   (rd_idx),
        .rd_ship  (p1_ship),
        .rd_hit   (p1_hit),
        .set_idx  (set_idx),
        .set_ship (place_do & ~place_player),
        .set_hit  (hit_now & ~tgt)
`ifdef COLISOR_MISS_MAP_EN
        ,
        .rd_miss  (p1_miss),
        .set_miss (miss_now & ~tgt)
`endif
    );

    board_bitmap #(.CELLS(CELLS), .IW(IW)) u_board_p2 (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_do),
        .rd_idx   (rd_idx),
        .rd_ship  (p2_ship),
        .rd_hit   (p2_hit),
        .set_idx  (set_idx),
        .set_ship (place_do & place_player),
        .set_hit  (hit_now & tgt)
`ifdef COLISOR_MISS_MAP_EN
        ,
        .rd_miss  (p2_miss),
        .set_miss (miss_now & tgt)
`endif
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state, shot decision and placement arbitration.
    always_comb begin
        state_n   = state;
        capture   = 1'b0;
        lookup    = 1'b0;
        res_load  = 1'b0;
        out_clr   = 1'b0;
        hit_now   = 1'b0;
        rep_now   = 1'b0;
        place_do  = 1'b0;
        place_rej = 1'b0;
        clear_do  = 1'b0;
`ifdef COLISOR_MISS_MAP_EN
        miss_now  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                clear_do = clear;
                if (req_edge) begin
                    capture = 1'b1;
                    state_n = LOOKUP;
                end
                if (place_we && !clear) begin
                    if (req_edge || !place_rng ||
                        sel_ship || full)
                        place_rej = 1'b1;
                    else
                        place_do = 1'b1;
                end
            end
            LOOKUP: begin
                lookup    = 1'b1;
                place_rej = place_we;
                state_n   = UPDATE;
            end
            UPDATE: begin
                res_load  = 1'b1;
                place_rej = place_we;
                state_n   = DONE;
                if (l_rng && l_ship && !l_hit)
                    hit_now = 1'b1;
                else if (l_rng && l_ship)
                    rep_now = 1'b1;
`ifdef COLISOR_MISS_MAP_EN
                else if (l_rng && l_miss)
                    rep_now = 1'b1;
                else if (l_rng)
                    miss_now = 1'b1;
`endif
            end
            DONE: begin
                place_rej = place_we;
                if (!shot_req) begin
                    out_clr = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    // Request edge history and captured shot coordinates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_prev <= 1'b0;
            tgt      <= 1'b0;
            sx       <= '0;
            sy       <= '0;
        end else begin
            req_prev <= shot_req;
            if (capture) begin
                tgt <= shot_target;
                sx  <= shot_x;
                sy  <= shot_y;
            end
        end
    end

    // Board bits of the captured cell, latched in LOOKUP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_rng  <= 1'b0;
            l_ship <= 1'b0;
            l_hit  <= 1'b0;
        end else if (lookup) begin
            l_rng  <= shot_rng;
            l_ship <= sel_ship;
            l_hit  <= sel_hit;
        end
    end

`ifdef COLISOR_MISS_MAP_EN
    // Miss bit of the captured cell, latched in LOOKUP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            l_miss <= 1'b0;
        else if (lookup)
            l_miss <= sel_miss;
    end
`endif

    // Remaining-ship counters: grow on placement, shrink on hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qtd_P1 <= '0;
            qtd_P2 <= '0;
        end else if (clear_do) begin
            qtd_P1 <= '0;
            qtd_P2 <= '0;
        end else begin
            if (place_do && !place_player)
                qtd_P1 <= qtd_P1 + 1'b1;
            if (place_do && place_player)
                qtd_P2 <= qtd_P2 + 1'b1;
            if (hit_now && !tgt && qtd_P1 != '0)
                qtd_P1 <= qtd_P1 - 1'b1;
            if (hit_now && tgt && qtd_P2 != '0)
                qtd_P2 <= qtd_P2 - 1'b1;
        end
    end

    // Result outputs held through DONE, placement error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acertou_tiro <= 1'b0;
            shot_repeat  <= 1'b0;
            shot_done    <= 1'b0;
            place_err    <= 1'b0;
        end else begin
            place_err <= place_rej;
            if (res_load) begin
                acertou_tiro <= hit_now;
                shot_repeat  <= rep_now;
                shot_done    <= 1'b1;
            end else if (out_clr) begin
                acertou_tiro <= 1'b0;
                shot_repeat  <= 1'b0;
                shot_done    <= 1'b0;
            end
        end
    end

endmodule
